// File: rtl/dct_product_accumulator.sv
// dct_product_accumulator
//   Sums TAPS consecutive signed products from the DCT multiplier array into
//   one coefficient, then rounds (half-up), arithmetically shifts by SHIFT
//   and saturates the result to OUT_W bits before handing it downstream.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous, active-high reset
//   i_in_valid     i_in_product / i_in_last are valid
//   o_in_ready     accumulator can accept a product (combinational from i_out_ready)
//   i_in_product   signed 2N-bit product
//   i_in_last      marks the final product of a coefficient
//   o_out_valid    o_out_coeff / o_out_sat / o_out_index are valid
//   i_out_ready    downstream accepts the output
//   o_out_coeff    rounded, saturated signed coefficient
//   o_out_sat      o_out_coeff was clipped
//   o_out_index    coefficient index within the block, wraps at TAPS
//   o_frame_err    sticky: i_in_last misaligned with the tap count
//
// TAPS must be a power of two >= 2, and OUT_W must not exceed 2N+clog2(TAPS)+1.

module dct_product_accumulator #(
  parameter int N     = 8,
  parameter int TAPS  = 8,
  parameter int OUT_W = 12,
  parameter int SHIFT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [2*N-1:0]           i_in_product,
  input  logic                     i_in_last,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [OUT_W-1:0]         o_out_coeff,
  output logic                     o_out_sat,
  output logic [$clog2(TAPS)-1:0]  o_out_index,
  output logic                     o_frame_err
);

  localparam int IDX_W = $clog2(TAPS);
  localparam int ACC_W = 2*N + IDX_W;
  // One extra bit so the rounding offset can never wrap the sum.
  localparam int RND_W = ACC_W + 1;

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  localparam logic signed [RND_W-1:0] ROUND_ADD =
    (SHIFT > 0) ? $signed(RND_W'(1) << (SHIFT - 1)) : $signed({RND_W{1'b0}});
  localparam logic signed [RND_W-1:0] SAT_MAX =
    $signed({{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [RND_W-1:0] SAT_MIN =
    $signed({{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  // Round half-up, arithmetic shift, clip; returns {clipped, coeff}.
  function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] sum);
    logic signed [RND_W-1:0] rnd;
    logic signed [RND_W-1:0] shf;
    rnd = $signed({sum[ACC_W-1], sum}) + ROUND_ADD;
    shf = rnd >>> SHIFT;
    if (shf > SAT_MAX) begin
      round_sat = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (shf < SAT_MIN) begin
      round_sat = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      round_sat = {1'b0, shf[OUT_W-1:0]};
    end
  endfunction

  logic [IDX_W-1:0]         r_tap_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic [OUT_W-1:0]         r_out_coeff;
  logic                     r_out_sat;
  logic [IDX_W-1:0]         r_out_index;
  logic                     r_frame_err;

  logic                     w_final;
  logic                     w_in_ready;
  logic                     w_in_fire;
  logic                     w_out_fire;
  logic                     w_early_last;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic [OUT_W:0]           w_result;

  assign w_final      = (r_tap_cnt == LAST_TAP);
  // The only stall: a finished sum cannot land while the previous one is still held.
  assign w_in_ready   = !(w_final && r_out_valid && !i_out_ready);
  assign w_in_fire    = i_in_valid && w_in_ready;
  assign w_out_fire   = r_out_valid && i_out_ready;
  assign w_early_last = w_in_fire && i_in_last && !w_final;
  assign w_prod_ext   = $signed({{IDX_W{i_in_product[2*N-1]}}, i_in_product});
  // Tap 0 starts a fresh sum; later taps add onto the running total.
  assign w_sum        = (r_tap_cnt == IDX_ZERO) ? w_prod_ext : (r_acc + w_prod_ext);
  assign w_result     = round_sat(w_sum);

  // Tap counter, running sum and the sticky framing error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tap_cnt   <= IDX_ZERO;
      r_acc       <= {ACC_W{1'b0}};
      r_frame_err <= 1'b0;
    end else if (w_in_fire) begin
      if (w_early_last) begin
        r_tap_cnt   <= IDX_ZERO;
        r_acc       <= {ACC_W{1'b0}};
        r_frame_err <= 1'b1;
      end else if (w_final) begin
        r_tap_cnt   <= IDX_ZERO;
        r_acc       <= {ACC_W{1'b0}};
        r_frame_err <= r_frame_err | !i_in_last;
      end else begin
        r_tap_cnt   <= r_tap_cnt + IDX_ONE;
        r_acc       <= w_sum;
        r_frame_err <= r_frame_err;
      end
    end else begin
      r_tap_cnt   <= r_tap_cnt;
      r_acc       <= r_acc;
      r_frame_err <= r_frame_err;
    end
  end

  // Output holding register; a new result may replace one accepted on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_coeff <= {OUT_W{1'b0}};
      r_out_sat   <= 1'b0;
    end else if (w_in_fire && w_final) begin
      r_out_valid <= 1'b1;
      r_out_coeff <= w_result[OUT_W-1:0];
      r_out_sat   <= w_result[OUT_W];
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
      r_out_coeff <= r_out_coeff;
      r_out_sat   <= r_out_sat;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_coeff <= r_out_coeff;
      r_out_sat   <= r_out_sat;
    end
  end

  // Coefficient index: advances per accepted output, restarts on an early in_last.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_index <= IDX_ZERO;
    end else if (w_early_last) begin
      r_out_index <= IDX_ZERO;
    end else if (w_out_fire) begin
      r_out_index <= r_out_index + IDX_ONE;
    end else begin
      r_out_index <= r_out_index;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_coeff = r_out_coeff;
  assign o_out_sat   = r_out_sat;
  assign o_out_index = r_out_index;
  assign o_frame_err = r_frame_err;

endmodule
